i2c_slave_rx_burst: RTL
=======================

Name: i2c_slave_rx_burst

Overview:
Parametrised I2C slave receive engine. It receives a runtime-programmable burst of 1..(2^LEN_W-1) bytes from the bus, MSB first. After each byte it generates the 9th-clock ACK/NACK itself and streams each completed byte out as a one-cycle valid pulse. It sits under the slave top-level FSM, after address match, in place of single-byte receive plus external ACK handling. It also filters bus glitches and aborts on START/STOP inside a byte.

Parameters:
LEN_W, 4, width of len and byte_index; maximum burst length is 2^LEN_W-1.
FILTER_LEN, 2, consecutive identical synchronised samples required before filtered scl/sda change; minimum 1.
TIMEOUT_CYCLES, 1024, SCL-low timeout in clk cycles; used only with I2C_RX_TIMEOUT_EN.

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
enable  input  1  one-cycle start pulse; len sampled in same cycle
len  input  LEN_W  bytes to receive
ack_en  input  1  sampled at each byte end: 1 = ACK, 0 = NACK and terminate
scl  input  1  raw bus SCL
sda  input  1  raw bus SDA
sda_oe  output  1  1 = pull SDA low (ACK); 0 = release
byte_data  output  8  last received byte; held until next byte_valid
byte_valid  output  1  one-cycle pulse per completed byte
byte_index  output  LEN_W  index of byte_data within burst, 0-based
busy  output  1  high from accepted enable until finish/error
finish  output  1  one-cycle pulse, burst complete
nacked  output  1  valid with finish: 1 = terminated by NACK
error  output  1  one-cycle pulse, burst aborted

Behaviour:
- Reset: all outputs 0; FSM IDLE; internal filtered scl/sda = 1.
- Input path: scl/sda each pass a 2-FF synchroniser, then the FILTER_LEN filter. Edges are detected on filtered values. All references below are to filtered edges.
- FSM states:
  - IDLE
    - enable with len!=0: latch len, clear bit/byte counters, busy=1 next cycle, go to BIT.
    - enable with len==0: error pulse next cycle, stay IDLE.
    - enable while busy: ignored.
  - BIT
    - On scl rising: shift sda into the shifter. On the 8th sample go to WAIT_FALL.
    - Next cycle: byte_data=shifter, byte_valid=1, byte_index=counter.
    - ack_en is sampled in the same cycle as the 8th rising edge.
  - WAIT_FALL
    - On scl falling: sda_oe = ack_en_sampled; go to ACK.
  - ACK
    - Holds sda_oe through the 9th clock.
    - On the next scl falling: sda_oe=0 in the same cycle.
    - If NACK or the last byte: finish=1, nacked=NACK, busy=0, go to IDLE.
    - Otherwise: byte counter +1, go to BIT.
- START/STOP detection: in BIT, an sda edge while filtered scl==1 and not coincident with an scl edge causes:
  - error pulse next cycle;
  - busy=0, sda_oe=0, return to IDLE;
  - partial byte discarded; no byte_valid.
  - In WAIT_FALL/ACK, sda edges are ignored.
- Counters: bit counter 3 bits, wraps 7->0 per byte. Byte counter LEN_W bits, never exceeds len-1.
- Simultaneous events: error beats finish. finish and error are never high in the same cycle.
- Reset mid-operation: sda_oe drops asynchronously with rst_n, even mid-ACK.

Optional Feature:
I2C_RX_TIMEOUT_EN: when defined, a counter runs while busy and scl is low, and clears on scl high.
- Reaching TIMEOUT_CYCLES: error pulse, sda_oe=0, IDLE.
- When undefined: no counter; the block waits indefinitely.

Test Plan:
1. len=4, ack_en=1, bus bytes 13,57,9B,DF, SCL = clk/8 → four byte_valid with data 13/57/9B/DF and index 0..3. sda_oe=1 exactly during each 9th clock. One finish, nacked=0, no error.
2. len=3, bytes A5,3C,FF, ack_en=0 during byte 1 → byte_valid for A5 (index 0) and 3C (index 1) only. sda_oe=0 in byte 1's 9th clock. finish with nacked=1; FF ignored.
3. len=2, after 3 bits of C3, sda rises while scl high → error pulse, no byte_valid, busy=0, sda_oe=0. A subsequent enable with len=1 and byte 5A → 5A received, finish.
4. FILTER_LEN=2, 1-clk low glitch on scl during high phase of every bit, len=1 byte 96 → byte 96 received correctly, no extra shifts, finish.
5. rst_n low while sda_oe=1 mid-ACK → sda_oe=0 immediately, all outputs 0. After release, enable len=1 byte 81 → works.
6. With I2C_RX_TIMEOUT_EN, TIMEOUT_CYCLES=1024, scl held low 1100 cycles mid-byte → error at cycle 1024, IDLE. Without the macro → no error, byte completes when SCL resumes.

Source files
------------

// File: rtl/i2c_slave_rx_burst.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : i2c_slave_rx_burst
// Purpose  : I2C slave burst receive engine. After address match the slave
//            top-level pulses 'enable' with a byte count. This block then
//            clocks in that many bytes MSB first. It drives the 9th-clock
//            ACK/NACK itself and streams each completed byte out with a
//            one-cycle valid pulse. SCL/SDA are synchronised and
//            glitch-filtered. A START/STOP seen inside a byte aborts the
//            burst.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters
//   LEN_W          width of len / byte_index (max burst = 2^LEN_W-1)
//   FILTER_LEN     identical synchronised samples needed to move a filtered
//                  line (>= 1)
//   TIMEOUT_CYCLES SCL-low timeout in clk cycles (timeout build only)
// Optional build macro
//   I2C_RX_TIMEOUT_EN  adds the SCL-low timeout abort while busy
// Ports
//   clk, rst_n     system clock, asynchronous active-low reset
//   enable, len    one-cycle start pulse with burst length (len 0 -> error)
//   ack_en         sampled at each byte end: 1 = ACK, 0 = NACK and terminate
//   scl, sda       raw bus lines
//   sda_oe         1 = pull SDA low (ACK)
//   byte_data      last received byte, held until the next byte_valid
//   byte_valid     one-cycle pulse per completed byte
//   byte_index     0-based position of byte_data in the burst
//   busy           burst in progress
//   finish/nacked  one-cycle completion pulse; nacked flags a NACK stop
//   error          one-cycle abort pulse
// ============================================================================
module i2c_slave_rx_burst #(
    parameter int LEN_W          = 4,
    parameter int FILTER_LEN     = 2,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             enable,
    input  logic [LEN_W-1:0] len,
    input  logic             ack_en,
    input  logic             scl,
    input  logic             sda,
    output logic             sda_oe,
    output logic [7:0]       byte_data,
    output logic             byte_valid,
    output logic [LEN_W-1:0] byte_index,
    output logic             busy,
    output logic             finish,
    output logic             nacked,
    output logic             error
);

    // ------------------------------------------------------------------
    // Input conditioning: channel 0 = SCL, channel 1 = SDA.
    // ------------------------------------------------------------------
    localparam int              FCNT_W   = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
    localparam logic [FCNT_W-1:0] FCNT_MAX = FCNT_W'(FILTER_LEN - 1);

    logic [1:0]             raw;
    logic [1:0]             sync1_q, sync1_d;
    logic [1:0]             sync2_q, sync2_d;
    logic [1:0]             filt_q,  filt_d;
    logic [1:0]             prev_q,  prev_d;
    logic [1:0][FCNT_W-1:0] fcnt_q,  fcnt_d;

    assign raw = {sda, scl};

    // The filter counts consecutive synchronised samples that disagree with
    // the filtered value. Any agreeing sample restarts the count, so a pulse
    // shorter than FILTER_LEN samples never reaches the filtered line.
    always_comb begin
        sync1_d = raw;
        sync2_d = sync1_q;
        prev_d  = filt_q;
        filt_d  = filt_q;
        fcnt_d  = fcnt_q;
        for (int i = 0; i < 2; i++) begin
            if (sync2_q[i] == filt_q[i]) begin
                fcnt_d[i] = '0;
            end else if (fcnt_q[i] == FCNT_MAX) begin
                filt_d[i] = sync2_q[i];
                fcnt_d[i] = '0;
            end else begin
                fcnt_d[i] = fcnt_q[i] + 1'b1;
            end
        end
    end

    // Idle bus level is high, so all conditioning stages reset to 1.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 2'b11;
            sync2_q <= 2'b11;
            filt_q  <= 2'b11;
            prev_q  <= 2'b11;
            fcnt_q  <= '0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            filt_q  <= filt_d;
            prev_q  <= prev_d;
            fcnt_q  <= fcnt_d;
        end
    end

    logic scl_f;
    logic sda_f;
    logic scl_rise;
    logic scl_fall;
    logic scl_edge;
    logic sda_edge;
    logic bus_cond;

    assign scl_f    = filt_q[0];
    assign sda_f    = filt_q[1];
    assign scl_rise =  filt_q[0] & ~prev_q[0];
    assign scl_fall = ~filt_q[0] &  prev_q[0];
    assign scl_edge =  filt_q[0] ^  prev_q[0];
    assign sda_edge =  filt_q[1] ^  prev_q[1];
    // SDA moving while SCL is steadily high is a START or STOP. An SDA edge
    // in the same cycle as an SCL edge is ambiguous and is not treated as one.
    assign bus_cond = sda_edge & scl_f & ~scl_edge;

    // ------------------------------------------------------------------
    // Receive state machine
    // ------------------------------------------------------------------
    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_BIT       = 2'd1,
        ST_WAIT_FALL = 2'd2,
        ST_ACK       = 2'd3
    } state_t;

    state_t           state_q,      state_d;
    logic [2:0]       bit_cnt_q,    bit_cnt_d;
    logic [LEN_W-1:0] byte_cnt_q,   byte_cnt_d;
    logic [LEN_W-1:0] len_q,        len_d;
    logic [6:0]       shift_q,      shift_d;
    logic             ack_q,        ack_d;
    logic             sda_oe_q,     sda_oe_d;
    logic [7:0]       byte_data_q,  byte_data_d;
    logic             byte_valid_q, byte_valid_d;
    logic [LEN_W-1:0] byte_index_q, byte_index_d;
    logic             busy_q,       busy_d;
    logic             finish_q,     finish_d;
    logic             nacked_q,     nacked_d;
    logic             error_q,      error_d;
    logic             timeout;

`ifdef I2C_RX_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [TO_W-1:0] to_cnt_q, to_cnt_d;

    // Counts busy cycles with SCL held low. Any SCL-high cycle or the end of
    // the burst clears it. The expiry cycle itself is the TIMEOUT_CYCLES-th
    // low cycle.
    always_comb begin
        to_cnt_d = '0;
        timeout  = 1'b0;
        if (busy_q && !scl_f) begin
            if (to_cnt_q == TO_W'(TIMEOUT_CYCLES - 1)) begin
                timeout = 1'b1;
            end else begin
                to_cnt_d = to_cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            to_cnt_q <= '0;
        end else begin
            to_cnt_q <= to_cnt_d;
        end
    end
`else
    // Without the timeout the engine waits indefinitely for SCL.
    // This comparison is always false, so timeout is tied off.
    assign timeout = (TIMEOUT_CYCLES < 0);
`endif

    always_comb begin
        state_d      = state_q;
        bit_cnt_d    = bit_cnt_q;
        byte_cnt_d   = byte_cnt_q;
        len_d        = len_q;
        shift_d      = shift_q;
        ack_d        = ack_q;
        sda_oe_d     = sda_oe_q;
        byte_data_d  = byte_data_q;
        byte_index_d = byte_index_q;
        busy_d       = busy_q;
        byte_valid_d = 1'b0;
        finish_d     = 1'b0;
        nacked_d     = 1'b0;
        error_d      = 1'b0;

        if ((state_q != ST_IDLE) && timeout) begin
            // Abort takes priority over every in-flight event, so finish can
            // never coincide with error.
            error_d  = 1'b1;
            busy_d   = 1'b0;
            sda_oe_d = 1'b0;
            state_d  = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    sda_oe_d = 1'b0;
                    if (enable) begin
                        if (len != '0) begin
                            len_d      = len;
                            bit_cnt_d  = '0;
                            byte_cnt_d = '0;
                            shift_d    = '0;
                            busy_d     = 1'b1;
                            state_d    = ST_BIT;
                        end else begin
                            error_d = 1'b1;
                        end
                    end
                end

                ST_BIT: begin
                    if (bus_cond) begin
                        // START/STOP inside a byte: drop the partial byte.
                        error_d  = 1'b1;
                        busy_d   = 1'b0;
                        sda_oe_d = 1'b0;
                        state_d  = ST_IDLE;
                    end else if (scl_rise) begin
                        shift_d   = {shift_q[5:0], sda_f};
                        bit_cnt_d = bit_cnt_q + 3'd1;
                        if (bit_cnt_q == 3'd7) begin
                            // Eighth bit: publish the byte and freeze the
                            // ACK decision for the coming 9th clock.
                            byte_data_d  = {shift_q, sda_f};
                            byte_valid_d = 1'b1;
                            byte_index_d = byte_cnt_q;
                            ack_d        = ack_en;
                            state_d      = ST_WAIT_FALL;
                        end
                    end
                end

                ST_WAIT_FALL: begin
                    // SDA may only be driven once SCL is low again.
                    if (scl_fall) begin
                        sda_oe_d = ack_q;
                        state_d  = ST_ACK;
                    end
                end

                ST_ACK: begin
                    // Falling edge ending the 9th clock releases SDA.
                    if (scl_fall) begin
                        sda_oe_d = 1'b0;
                        if (!ack_q || (byte_cnt_q == (len_q - LEN_W'(1)))) begin
                            finish_d = 1'b1;
                            nacked_d = ~ack_q;
                            busy_d   = 1'b0;
                            state_d  = ST_IDLE;
                        end else begin
                            byte_cnt_d = byte_cnt_q + 1'b1;
                            state_d    = ST_BIT;
                        end
                    end
                end

                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    // Asynchronous reset also drops sda_oe instantly, even mid-ACK.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            bit_cnt_q    <= '0;
            byte_cnt_q   <= '0;
            len_q        <= '0;
            shift_q      <= '0;
            ack_q        <= 1'b0;
            sda_oe_q     <= 1'b0;
            byte_data_q  <= '0;
            byte_valid_q <= 1'b0;
            byte_index_q <= '0;
            busy_q       <= 1'b0;
            finish_q     <= 1'b0;
            nacked_q     <= 1'b0;
            error_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            bit_cnt_q    <= bit_cnt_d;
            byte_cnt_q   <= byte_cnt_d;
            len_q        <= len_d;
            shift_q      <= shift_d;
            ack_q        <= ack_d;
            sda_oe_q     <= sda_oe_d;
            byte_data_q  <= byte_data_d;
            byte_valid_q <= byte_valid_d;
            byte_index_q <= byte_index_d;
            busy_q       <= busy_d;
            finish_q     <= finish_d;
            nacked_q     <= nacked_d;
            error_q      <= error_d;
        end
    end

    assign sda_oe     = sda_oe_q;
    assign byte_data  = byte_data_q;
    assign byte_valid = byte_valid_q;
    assign byte_index = byte_index_q;
    assign busy       = busy_q;
    assign finish     = finish_q;
    assign nacked     = nacked_q;
    assign error      = error_q;

endmodule
`default_nettype wire
